prg_loader: RTL and testbench
=============================

Name: prg_loader

Overview:
- Streams an iNES image into the PRG ROM write port at power-up, byte by byte over a valid/ready interface.
- Holds the CPU in reset until the image is loaded, replacing hierarchical ROM pokes with a synthesizable boot path.
- Sits between the host byte source (UART/SPI bridge) and the PRG memory inside tarunes_top.
- Writes into the memory the CPU fetches from, so it is the writer for the CPU's reader.

Parameters:
- PRG_AW, 15, PRG memory address width (32 KB, CPU $8000-$FFFF maps to addr[14:0]).
- CHR_AW, 13, CHR memory address width (8 KB).
- HDR_LEN, 16, iNES header length in bytes.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader accepts the byte this cycle when in_valid is also high.
- reload  in  1  one-cycle pulse; restarts loading from DONE or ERR.
- prg_we  out  1  PRG write strobe.
- prg_addr  out  PRG_AW  PRG write address.
- prg_wdata  out  8  PRG write data.
- chr_we  out  1  CHR write strobe (PRG_LOADER_CHR_EN only).
- chr_addr  out  CHR_AW  CHR write address (PRG_LOADER_CHR_EN only).
- chr_wdata  out  8  CHR write data (PRG_LOADER_CHR_EN only).
- cpu_rst  out  1  active-low CPU reset; 0 until load completes.
- busy  out  1  high in HDR/PRG/MIRROR/CHR.
- done  out  1  high in DONE.
- error  out  1  high in ERR.

Behaviour:
- Reset (rst=0 at a clk edge) gives:
  - state HDR;
  - in_ready=0 during reset, 1 from the first cycle after reset in HDR;
  - prg_we=0, chr_we=0, all addresses/data 0;
  - cpu_rst=0, busy=1, done=0, error=0;
  - all counters cleared.
- A handshake is in_valid&&in_ready at a rising edge. in_data is sampled there.
- HDR state:
  - Counts header bytes 0..HDR_LEN-1.
  - Bytes 0-3 must be 4E 45 53 1A. Mismatch -> ERR on that byte.
  - Byte 4 (prg16k) must be 1 or 2, else ERR. It is latched.
  - Byte 5 (chr8k) must be 0 or 1, else ERR. It is latched.
  - Byte 6 bit2 (trainer) set -> ERR.
  - Bytes 7-15 are ignored.
  - After byte 15 -> PRG, with the PRG address counter at 0.
- PRG state:
  - Each handshake produces a registered write one cycle later: prg_we=1, prg_addr=counter, prg_wdata=byte. The counter then increments.
  - If prg16k==1, state -> MIRROR for one cycle. in_ready=0 in MIRROR.
  - The MIRROR cycle issues a second write at prg_addr=counter|0x4000, same data, two cycles after the handshake.
  - The last PRG byte is counter 0x3FFF (prg16k=1) or 0x7FFF (prg16k=2). After it: chr8k==1 -> CHR, else -> DONE.
- CHR state: consumes 8192 bytes with in_ready=1. Address counter 0..0x1FFF. After the last byte -> DONE.
- DONE state:
  - in_ready=0, cpu_rst=1, done=1, busy=0.
  - Entered on the cycle after the final write strobe, so cpu_rst rises only after the last memory write commits.
- ERR state:
  - in_ready=0, cpu_rst stays 0, error=1, busy=0.
  - No further writes are issued.
- Write strobes are single-cycle. prg_we and chr_we are never high together.
- reload in DONE or ERR:
  - next state HDR; counters cleared, done/error cleared;
  - cpu_rst=0 on the next cycle.
  - reload in any other state is ignored.
- rst low mid-load aborts immediately to the reset values. Memory contents are left as-is, with no cleanup writes.
- Idle input (in_valid=0) stalls any state indefinitely. No timeout.
- Counters: PRG counter is PRG_AW bits, CHR counter CHR_AW bits. Completion is detected by compare; wraparound is never relied on.

Optional Feature:
- Macro PRG_LOADER_CHR_EN.
- Defined: the chr_we/chr_addr/chr_wdata ports exist. In CHR state each handshake gives chr_we=1 one cycle later, with chr_addr=counter and chr_wdata=byte.
- Undefined: the CHR ports are absent. CHR bytes are still accepted and counted but discarded. State sequencing and timing are identical.

Test Plan:
- Header 4E 45 53 1A 02 00 + 10 zero bytes, then 32768 PRG bytes with byte 0x7FFC=00 and 0x7FFD=80 -> 32768 prg_we pulses ending at addr 7FFF; DONE one cycle after the last write; cpu_rst=1. Bus model then shows the CPU fetching reset vector $8000.
- prg16k=01, 16384 bytes with byte 0x0000=78 -> writes 78 to addr 0000 and 4000 on consecutive cycles; in_ready low in each MIRROR cycle; total 32768 writes.
- Header byte 2 = 54 -> ERR on that byte; error=1; in_ready=0; cpu_rst=0; zero prg_we pulses. A reload pulse then returns busy=1 with error=0.
- prg16k=01, chr8k=01, 8192 CHR bytes A5 -> DONE after CHR. With PRG_LOADER_CHR_EN: 8192 chr_we pulses, last at 1FFF. Without it: no CHR writes and identical DONE cycle.
- in_valid toggled 1/0 every cycle during PRG -> writes track handshakes exactly, with no duplicate or dropped address.
- rst driven low after PRG byte 100 and released -> state HDR; prg_we=0; cpu_rst=0; a fresh full image then loads to DONE normally.

Source files
------------

// File: rtl/prg_loader.sv
// Boot loader: streams an iNES image from a byte source into PRG (and optionally CHR) memory,
// holding the CPU in reset until done. Optional CHR write port: define PRG_LOADER_CHR_EN.
module prg_loader #(
  parameter int PRG_AW  = 15,
  parameter int CHR_AW  = 13,
  parameter int HDR_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              prg_we,
  output logic [PRG_AW-1:0] prg_addr,
  output logic [7:0]        prg_wdata,
`ifdef PRG_LOADER_CHR_EN
  output logic              chr_we,
  output logic [CHR_AW-1:0] chr_addr,
  output logic [7:0]        chr_wdata,
`endif
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int HW = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;
  localparam logic [HW-1:0]     HDR_LAST  = HW'(HDR_LEN - 1);
  localparam logic [PRG_AW-1:0] PRG_HALF  = {1'b1, {(PRG_AW-1){1'b0}}};
  localparam logic [PRG_AW-1:0] PRG_LAST1 = {1'b0, {(PRG_AW-1){1'b1}}};
  localparam logic [PRG_AW-1:0] PRG_LAST2 = '1;
  localparam logic [CHR_AW-1:0] CHR_LAST  = '1;

  // S_FLUSH is an internal busy cycle so DONE starts only after the final write strobe.
  typedef enum logic [2:0] {
    S_HDR, S_PRG, S_MIRROR, S_CHR, S_FLUSH, S_DONE, S_ERR
  } state_t;

  state_t              state, nxt;
  logic [HW-1:0]       hdr_cnt, nxt_hdr_cnt;
  logic [PRG_AW-1:0]   prg_cnt, nxt_prg_cnt;
  logic [CHR_AW-1:0]   chr_cnt, nxt_chr_cnt;
  logic                prg_two, nxt_prg_two;
  logic                chr_one, nxt_chr_one;
  logic                nxt_prg_we;
  logic [PRG_AW-1:0]   nxt_prg_addr;
  logic [7:0]          nxt_prg_wdata;
`ifdef PRG_LOADER_CHR_EN
  logic                nxt_chr_we;
  logic [CHR_AW-1:0]   nxt_chr_addr;
  logic [7:0]          nxt_chr_wdata;
`endif
  logic                hs;

  assign in_ready = rst && (state == S_HDR || state == S_PRG || state == S_CHR);
  assign hs       = in_valid && in_ready;
  assign cpu_rst  = (state == S_DONE);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign busy     = !(state == S_DONE || state == S_ERR);

  always_comb begin
    nxt           = state;
    nxt_hdr_cnt   = hdr_cnt;
    nxt_prg_cnt   = prg_cnt;
    nxt_chr_cnt   = chr_cnt;
    nxt_prg_two   = prg_two;
    nxt_chr_one   = chr_one;
    nxt_prg_we    = 1'b0;
    nxt_prg_addr  = prg_addr;
    nxt_prg_wdata = prg_wdata;
`ifdef PRG_LOADER_CHR_EN
    nxt_chr_we    = 1'b0;
    nxt_chr_addr  = chr_addr;
    nxt_chr_wdata = chr_wdata;
`endif
    case (state)
      S_HDR: if (hs) begin
        nxt_hdr_cnt = hdr_cnt + 1'b1;
        case (hdr_cnt)
          HW'(0): if (in_data != 8'h4E) nxt = S_ERR;
          HW'(1): if (in_data != 8'h45) nxt = S_ERR;
          HW'(2): if (in_data != 8'h53) nxt = S_ERR;
          HW'(3): if (in_data != 8'h1A) nxt = S_ERR;
          HW'(4): begin
            if (in_data != 8'd1 && in_data != 8'd2) nxt = S_ERR;
            nxt_prg_two = (in_data == 8'd2);
          end
          HW'(5): begin
            if (in_data != 8'd0 && in_data != 8'd1) nxt = S_ERR;
            nxt_chr_one = (in_data == 8'd1);
          end
          HW'(6): if (in_data[2]) nxt = S_ERR;
          default: ;
        endcase
        if (hdr_cnt == HDR_LAST && nxt != S_ERR) begin
          nxt         = S_PRG;
          nxt_prg_cnt = '0;
        end
      end
      S_PRG: if (hs) begin
        nxt_prg_we    = 1'b1;
        nxt_prg_addr  = prg_cnt;
        nxt_prg_wdata = in_data;
        nxt_prg_cnt   = prg_cnt + 1'b1;
        if (!prg_two) nxt = S_MIRROR;
        else if (prg_cnt == PRG_LAST2) begin
          nxt         = chr_one ? S_CHR : S_FLUSH;
          nxt_chr_cnt = '0;
        end
      end
      S_MIRROR: begin
        nxt_prg_we   = 1'b1;
        nxt_prg_addr = prg_addr | PRG_HALF;
        if (prg_addr == PRG_LAST1) begin
          nxt         = chr_one ? S_CHR : S_FLUSH;
          nxt_chr_cnt = '0;
        end else begin
          nxt = S_PRG;
        end
      end
      S_CHR: if (hs) begin
`ifdef PRG_LOADER_CHR_EN
        nxt_chr_we    = 1'b1;
        nxt_chr_addr  = chr_cnt;
        nxt_chr_wdata = in_data;
`endif
        nxt_chr_cnt = chr_cnt + 1'b1;
        if (chr_cnt == CHR_LAST) nxt = S_FLUSH;
      end
      S_FLUSH: nxt = S_DONE;
      S_DONE, S_ERR: if (reload) begin
        nxt         = S_HDR;
        nxt_hdr_cnt = '0;
        nxt_prg_cnt = '0;
        nxt_chr_cnt = '0;
      end
      default: nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_HDR;
      hdr_cnt   <= '0;
      prg_cnt   <= '0;
      chr_cnt   <= '0;
      prg_two   <= 1'b0;
      chr_one   <= 1'b0;
      prg_we    <= 1'b0;
      prg_addr  <= '0;
      prg_wdata <= '0;
`ifdef PRG_LOADER_CHR_EN
      chr_we    <= 1'b0;
      chr_addr  <= '0;
      chr_wdata <= '0;
`endif
    end else begin
      state     <= nxt;
      hdr_cnt   <= nxt_hdr_cnt;
      prg_cnt   <= nxt_prg_cnt;
      chr_cnt   <= nxt_chr_cnt;
      prg_two   <= nxt_prg_two;
      chr_one   <= nxt_chr_one;
      prg_we    <= nxt_prg_we;
      prg_addr  <= nxt_prg_addr;
      prg_wdata <= nxt_prg_wdata;
`ifdef PRG_LOADER_CHR_EN
      chr_we    <= nxt_chr_we;
      chr_addr  <= nxt_chr_addr;
      chr_wdata <= nxt_chr_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_prg_loader.sv
// Bench for prg_loader with reduced memory sizes: header-check vector table, then randomized
// image loads compared against an expected write list derived from the image contents.
module tb_prg_loader;

  localparam int PAW  = 13;
  localparam int CAW  = 11;
  localparam int HALF = 1 << (PAW - 1);
  localparam int CHRN = 1 << CAW;
  localparam int MASK = (1 << PAW) - 1;

  logic clk = 1'b0;
  logic rst, in_valid, reload, in_ready;
  logic [7:0] in_data;
  logic prg_we;
  logic [PAW-1:0] prg_addr;
  logic [7:0] prg_wdata;
`ifdef PRG_LOADER_CHR_EN
  logic chr_we;
  logic [CAW-1:0] chr_addr;
  logic [7:0] chr_wdata;
`endif
  logic cpu_rst, busy, done, error;

  prg_loader #(.PRG_AW(PAW), .CHR_AW(CAW), .HDR_LEN(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .prg_we(prg_we), .prg_addr(prg_addr), .prg_wdata(prg_wdata),
`ifdef PRG_LOADER_CHR_EN
    .chr_we(chr_we), .chr_addr(chr_addr), .chr_wdata(chr_wdata),
`endif
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int prg_pulses = 0;
  int chr_pulses = 0;
  logic prev_ready = 1'b0;
  logic [7:0] mem [0:(1<<PAW)-1];

  typedef struct { bit is_chr; int addr; logic [7:0] data; int cyc; bit mirror; } wr_t;
  wr_t expq[$];

  typedef struct { int idx; logic [7:0] val; bit err; } hvec_t;
  hvec_t tbl[12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s cycle=%0d", name, cyc);
  endtask

  // Write monitor: every strobe must match the head of the expected write list.
  always @(negedge clk) begin
    wr_t e;
    if (prg_we) begin
      prg_pulses++;
      mem[prg_addr] = prg_wdata;
      if (expq.size() == 0) flag("unexpected_prg_we");
      else begin
        e = expq.pop_front();
        chk("prg_kind", 32'(e.is_chr), 32'd0);
        chk("prg_addr", 32'(prg_addr), e.addr);
        chk("prg_wdata", 32'(prg_wdata), 32'(e.data));
        chk("prg_cycle", cyc, e.cyc);
        if (e.mirror) chk("in_ready_in_mirror", 32'(prev_ready), 32'd0);
      end
    end
`ifdef PRG_LOADER_CHR_EN
    if (prg_we && chr_we) flag("prg_chr_overlap");
    if (chr_we) begin
      chr_pulses++;
      if (expq.size() == 0) flag("unexpected_chr_we");
      else begin
        e = expq.pop_front();
        chk("chr_kind", 32'(e.is_chr), 32'd1);
        chk("chr_addr", 32'(chr_addr), e.addr);
        chk("chr_wdata", 32'(chr_wdata), 32'(e.data));
        chk("chr_cycle", cyc, e.cyc);
      end
    end
`endif
    prev_ready = in_ready;
  end

  task automatic bail(input string name);
    flag(name);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic send(input logic [7:0] b, output int hc);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) bail("send_timeout");
    hc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic pulse_reload();
    @(posedge clk); #1;
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    chk("reload_busy", 32'(busy), 32'd1);
    chk("reload_error", 32'(error), 32'd0);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("reload_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic load_image(input int p16, input int c8, input bit toggle, input int abort_at);
    logic [7:0] hdr [16];
    logic [7:0] b;
    int n, hc, last_hc, tail, base, w;
    if (done || error) pulse_reload();
    n = p16 * HALF;
    base = prg_pulses;
    hdr[0] = 8'h4E; hdr[1] = 8'h45; hdr[2] = 8'h53; hdr[3] = 8'h1A;
    hdr[4] = 8'(p16); hdr[5] = 8'(c8); hdr[6] = 8'($urandom) & 8'hFB;
    for (int i = 7; i < 16; i++) hdr[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) send(hdr[i], hc);
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? 8'h78 : (i == n - 4) ? 8'h00 : (i == n - 3) ? 8'h80 : 8'($urandom);
      send(b, hc);
      expq.push_back('{1'b0, i, b, hc + 1, 1'b0});
      if (p16 == 1) expq.push_back('{1'b0, i | HALF, b, hc + 2, 1'b1});
      if (toggle) begin
        in_data = 8'($urandom);
        @(posedge clk); #1;
      end
      if (i == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_prg_we", 32'(prg_we), 32'd0);
        chk("abort_prg_addr", 32'(prg_addr), 32'd0);
        chk("abort_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pulses", prg_pulses - base, i + 1);
        @(posedge clk); #1;
        rst = 1'b1;
        expq.delete();
        return;
      end
    end
    last_hc = hc;
    tail = (p16 == 1) ? 3 : 2;
    if (c8 == 1) begin
      for (int i = 0; i < CHRN; i++) begin
        send(8'hA5, hc);
`ifdef PRG_LOADER_CHR_EN
        expq.push_back('{1'b1, i, 8'hA5, hc + 1, 1'b0});
`endif
      end
      last_hc = hc;
      tail = 2;
    end
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!done && w < 20);
    chk("done", 32'(done), 32'd1);
    chk("done_cycle", cyc, last_hc + tail);
    chk("done_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_error", 32'(error), 32'd0);
    chk("pending_writes", expq.size(), 32'd0);
    chk("prg_write_count", prg_pulses - base, (p16 == 1) ? 2 * n : n);
    chk("reset_vector", {16'd0, mem[16'hFFFD & MASK], mem[16'hFFFC & MASK]}, 32'h8000);
    chk("byte0", 32'(mem[0]), 32'h78);
    if (p16 == 1) chk("byte0_mirror", 32'(mem[HALF]), 32'h78);
    @(posedge clk); #1;
  endtask

  initial begin
    int hc, base, last;
    logic [7:0] hdr [16];
    int chr_base;

    tbl[0]  = '{0, 8'h4D, 1'b1};
    tbl[1]  = '{1, 8'h00, 1'b1};
    tbl[2]  = '{2, 8'h54, 1'b1};
    tbl[3]  = '{3, 8'h1B, 1'b1};
    tbl[4]  = '{4, 8'h00, 1'b1};
    tbl[5]  = '{4, 8'h03, 1'b1};
    tbl[6]  = '{5, 8'h02, 1'b1};
    tbl[7]  = '{6, 8'h04, 1'b1};
    tbl[8]  = '{6, 8'hFB, 1'b0};
    tbl[9]  = '{5, 8'h01, 1'b0};
    tbl[10] = '{7, 8'hFF, 1'b0};
    tbl[11] = '{15, 8'hAA, 1'b0};

    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    for (int i = 0; i < (1 << PAW); i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_prg_we", 32'(prg_we), 32'd0);
    chk("rst_prg_addr", 32'(prg_addr), 32'd0);
    chk("rst_prg_wdata", 32'(prg_wdata), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      do_reset();
      hdr[0] = 8'h4E; hdr[1] = 8'h45; hdr[2] = 8'h53; hdr[3] = 8'h1A;
      hdr[4] = 8'h01; hdr[5] = 8'h00;
      for (int i = 6; i < 16; i++) hdr[i] = 8'h00;
      hdr[tbl[k].idx] = tbl[k].val;
      base = prg_pulses;
      last = tbl[k].err ? tbl[k].idx : 15;
      for (int i = 0; i <= last; i++) send(hdr[i], hc);
      @(negedge clk);
      chk($sformatf("hdr%0d_error", k), 32'(error), 32'(tbl[k].err));
      chk($sformatf("hdr%0d_busy", k), 32'(busy), 32'(!tbl[k].err));
      chk($sformatf("hdr%0d_in_ready", k), 32'(in_ready), 32'(!tbl[k].err));
      chk($sformatf("hdr%0d_cpu_rst", k), 32'(cpu_rst), 32'd0);
      chk($sformatf("hdr%0d_prg_pulses", k), prg_pulses - base, 32'd0);
      if (tbl[k].err) begin
        repeat (3) @(negedge clk);
        chk($sformatf("hdr%0d_no_writes", k), prg_pulses - base, 32'd0);
        pulse_reload();
      end else begin
        @(posedge clk); #1;
      end
    end
    do_reset();

    load_image(2, 0, 1'b0, -1);
    load_image(1, 0, 1'b0, -1);
    chr_base = chr_pulses;
    load_image(1, 1, 1'b0, -1);
`ifdef PRG_LOADER_CHR_EN
    chk("chr_write_count", chr_pulses - chr_base, CHRN);
`endif
    load_image(2, 0, 1'b1, -1);
    load_image(2, 0, 1'b0, 100);
    load_image(2, 0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
